mm_operand_pe_slice: RTL and testbench
======================================

Name: mm_operand_pe_slice

Overview:
- Corner slice of the 4x4 systolic matrix-multiply datapath.
- Holds operand bank A (rows) and operand bank B (columns). Each bank is 128 x 16-bit with one write port and four registered read ports.
- Also holds the corner processing element (MAC) fed by read port 0 of both banks.
- Read ports 1-3 are exported to the controller's external skew delay chains. PE pass-through and accumulator outputs feed the neighbouring PEs and the output memory.

Parameters:
- DW, 16, operand width (bank word and PE A/B width).
- AW, 7, bank address width; depth = 2^AW = 128.
- CW, 33, accumulator / C_out width (2*DW+1).

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  asynchronous, active-low reset
- w_en_a  in  1  bank A write enable
- w_addr_a  in  AW  bank A write address
- w_data_a  in  DW  bank A write data
- r_en_a  in  1  bank A read enable (all four ports)
- r_addr_a0..r_addr_a3  in  AW each  bank A read addresses
- r_data_a1..r_data_a3  out  DW each  bank A registered read data, ports 1-3
- w_en_b, w_addr_b, w_data_b, r_en_b, r_addr_b0..3, r_data_b1..3  same as the A set, for bank B
- pe_en  in  1  PE enable (accumulate and shift)
- pe_clr  in  1  synchronous active-high PE clear
- pe_a_out  out  DW  registered A pass-through (to the right-hand neighbour)
- pe_b_out  out  DW  registered B pass-through (to the neighbour below)
- pe_c_out  out  CW  accumulator value

Behaviour:
- Reset (rst=0, asynchronous): all bank words = 0; all read-data registers = 0; pe_a_out, pe_b_out, pe_c_out = 0. Release of reset is synchronous to clk.
- Write: when w_en=1 at a clk edge, mem[w_addr] <= w_data. The write is ignored when w_addr = 127.
- Address 127 is the reserved "blank" word and always reads 0. The controller parks addresses at 127 to stream zeros into the array.
- Read: at each clk edge, for each port p, r_data_p <= r_en ? mem[r_addr_p] : 0. Latency is 1 cycle.
- The four ports are fully independent; identical addresses on several ports are legal.
- Read-during-write to the same address returns the old data (read-first). The new data is visible on the next read.
- Port 0 read data of A and B is internal only and drives PE inputs A and B directly.
- PE priority per clk edge: pe_clr > pe_en > hold.
  - pe_clr=1: c <= 0, a_out <= 0, b_out <= 0, regardless of pe_en.
  - pe_en=1: c <= c + A*B; a_out <= A; b_out <= B.
  - Both low: all PE registers hold.
- Arithmetic: unsigned 16x16 -> 32-bit product, zero-extended to 33 bits. The accumulator wraps modulo 2^33 and raises no overflow flag.
- The PE has no handshake; the controller sequences pe_en and pe_clr.
- Banks A and B are identical in structure and behaviour.

Optional Feature:
- Macro: MM_SIGNED_MAC_EN.
- Defined: operands are two's-complement; the product is sign-extended to 33 bits and accumulated signed, wrapping modulo 2^33.
- Undefined: unsigned arithmetic as specified above.
- Banks are unaffected in both cases.

Test Plan:
- Reset/blank word: assert rst=0 mid-accumulation with pe_c_out=0x1234 -> all outputs go 0 immediately without waiting for a clock edge. Then write 0xBEEF to A[127], read A[127] with r_en_a=1 -> r_data_a1 = 0.
- Bank read latency: write A[5]=0x0011 and B[9]=0x0022, then present r_addr_a1=5, r_addr_b3=9 with r_en=1 -> values appear exactly 1 cycle later. With r_en=0 -> outputs 0.
- Read-first: write A[3]=0x7 while reading A[3] (old value 0x2) in the same cycle -> r_data_a2=0x2; next cycle -> 0x7.
- MAC: stream A=1,2,3,4 and B=5,6,7,8 via addresses 0-3 with pe_en=1 -> pe_c_out=70; pe_a_out/pe_b_out follow the inputs with 1-cycle delay. Then pulse pe_clr=1 -> pe_c_out=0.
- Hold/priority: pe_en=0 -> pe_c_out holds 70. Assert pe_clr=1 together with pe_en=1 -> pe_c_out=0.
- Wrap: accumulate 0xFFFF*0xFFFF three times -> pe_c_out = 3*0xFFFE0001 mod 2^33 = 0x0FFFA0003. With MM_SIGNED_MAC_EN and 0xFFFF*0x0002 -> pe_c_out = 0x1FFFFFFFE (-2).

Source files
------------

// File: rtl/mm_operand_pe_slice.sv
// rtl/mm_operand_pe_slice.sv - corner slice: operand banks A/B (4 read ports each) and corner MAC PE
// Optional: define MM_SIGNED_MAC_EN for two's-complement MAC arithmetic (default unsigned).

module mm_operand_bank #(
  parameter int DW = 16,
  parameter int AW = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  input  logic                  r_en,
  input  logic [3:0][AW-1:0]    r_addr,
  output logic [3:0][DW-1:0]    r_data
);
  localparam int DEPTH = 2 ** AW;
  // Top address is the blank word: never written, always reads zero.
  localparam logic [AW-1:0] BLANK = '1;

  logic [DW-1:0]      mem_q [DEPTH];
  logic [3:0][DW-1:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    for (int p = 0; p < 4; p++) begin
      if (r_en && (r_addr[p] != BLANK)) begin
        rd_d[p] = mem_q[r_addr[p]];
      end
    end
  end

  // Reads sample mem_q before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (w_en && (w_addr != BLANK)) begin
        mem_q[w_addr] <= w_data;
      end
      rd_q <= rd_d;
    end
  end

  assign r_data = rd_q;
endmodule

module mm_operand_pe_slice #(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int CW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_en_a,
  input  logic [AW-1:0] w_addr_a,
  input  logic [DW-1:0] w_data_a,
  input  logic          r_en_a,
  input  logic [AW-1:0] r_addr_a0,
  input  logic [AW-1:0] r_addr_a1,
  input  logic [AW-1:0] r_addr_a2,
  input  logic [AW-1:0] r_addr_a3,
  output logic [DW-1:0] r_data_a1,
  output logic [DW-1:0] r_data_a2,
  output logic [DW-1:0] r_data_a3,
  input  logic          w_en_b,
  input  logic [AW-1:0] w_addr_b,
  input  logic [DW-1:0] w_data_b,
  input  logic          r_en_b,
  input  logic [AW-1:0] r_addr_b0,
  input  logic [AW-1:0] r_addr_b1,
  input  logic [AW-1:0] r_addr_b2,
  input  logic [AW-1:0] r_addr_b3,
  output logic [DW-1:0] r_data_b1,
  output logic [DW-1:0] r_data_b2,
  output logic [DW-1:0] r_data_b3,
  input  logic          pe_en,
  input  logic          pe_clr,
  output logic [DW-1:0] pe_a_out,
  output logic [DW-1:0] pe_b_out,
  output logic [CW-1:0] pe_c_out
);
  logic [3:0][DW-1:0] rd_a, rd_b;

  mm_operand_bank #(.DW(DW), .AW(AW)) u_bank_a (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_en_a),
    .w_addr (w_addr_a),
    .w_data (w_data_a),
    .r_en   (r_en_a),
    .r_addr ({r_addr_a3, r_addr_a2, r_addr_a1, r_addr_a0}),
    .r_data (rd_a)
  );

  mm_operand_bank #(.DW(DW), .AW(AW)) u_bank_b (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_en_b),
    .w_addr (w_addr_b),
    .w_data (w_data_b),
    .r_en   (r_en_b),
    .r_addr ({r_addr_b3, r_addr_b2, r_addr_b1, r_addr_b0}),
    .r_data (rd_b)
  );

  assign r_data_a1 = rd_a[1];
  assign r_data_a2 = rd_a[2];
  assign r_data_a3 = rd_a[3];
  assign r_data_b1 = rd_b[1];
  assign r_data_b2 = rd_b[2];
  assign r_data_b3 = rd_b[3];

  logic [2*DW-1:0] prod;
  logic [CW-1:0]   prod_ext;

  // Operands are widened before multiplying so the full product is kept.
`ifdef MM_SIGNED_MAC_EN
  assign prod     = $signed({{DW{rd_a[0][DW-1]}}, rd_a[0]}) * $signed({{DW{rd_b[0][DW-1]}}, rd_b[0]});
  assign prod_ext = {{(CW-2*DW){prod[2*DW-1]}}, prod};
`else
  assign prod     = {{DW{1'b0}}, rd_a[0]} * {{DW{1'b0}}, rd_b[0]};
  assign prod_ext = {{(CW-2*DW){1'b0}}, prod};
`endif

  logic [CW-1:0] c_q, c_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;

  always_comb begin
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    if (pe_clr) begin
      c_d = '0;
      a_d = '0;
      b_d = '0;
    end else if (pe_en) begin
      c_d = c_q + prod_ext;
      a_d = rd_a[0];
      b_d = rd_b[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign pe_a_out = a_q;
  assign pe_b_out = b_q;
  assign pe_c_out = c_q;
endmodule

// File: tb/tb_mm_operand_pe_slice.sv
// tb/tb_mm_operand_pe_slice.sv - scoreboard bench for mm_operand_pe_slice (honours MM_SIGNED_MAC_EN)

module tb_mm_operand_pe_slice;
  logic        clk;
  logic        rst;
  logic        w_en_a, w_en_b, r_en_a, r_en_b;
  logic [6:0]  w_addr_a, w_addr_b;
  logic [15:0] w_data_a, w_data_b;
  logic [6:0]  ra [4];
  logic [6:0]  rb [4];
  logic [15:0] r_data_a1, r_data_a2, r_data_a3, r_data_b1, r_data_b2, r_data_b3;
  logic        pe_en, pe_clr;
  logic [15:0] pe_a_out, pe_b_out;
  logic [32:0] pe_c_out;

  mm_operand_pe_slice dut (
    .clk(clk), .rst(rst),
    .w_en_a(w_en_a), .w_addr_a(w_addr_a), .w_data_a(w_data_a), .r_en_a(r_en_a),
    .r_addr_a0(ra[0]), .r_addr_a1(ra[1]), .r_addr_a2(ra[2]), .r_addr_a3(ra[3]),
    .r_data_a1(r_data_a1), .r_data_a2(r_data_a2), .r_data_a3(r_data_a3),
    .w_en_b(w_en_b), .w_addr_b(w_addr_b), .w_data_b(w_data_b), .r_en_b(r_en_b),
    .r_addr_b0(rb[0]), .r_addr_b1(rb[1]), .r_addr_b2(rb[2]), .r_addr_b3(rb[3]),
    .r_data_b1(r_data_b1), .r_data_b2(r_data_b2), .r_data_b3(r_data_b3),
    .pe_en(pe_en), .pe_clr(pe_clr),
    .pe_a_out(pe_a_out), .pe_b_out(pe_b_out), .pe_c_out(pe_c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a1, a2, a3, b1, b2, b3, pa, pb;
    logic [32:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model state
  int unsigned mem_a [128];
  int unsigned mem_b [128];
  logic [15:0] rd0a, rd0b, pa_m, pb_m;
  logic [32:0] c_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic longint mul(input logic [15:0] a, input logic [15:0] b);
`ifdef MM_SIGNED_MAC_EN
    return longint'($signed(a)) * longint'($signed(b));
`else
    return longint'(a) * longint'(b);
`endif
  endfunction

  function automatic logic [15:0] rd_model(input logic en, input logic [6:0] addr, input logic is_a);
    if (!en || addr == 7'd127) return 16'h0;
    return is_a ? 16'(mem_a[addr]) : 16'(mem_b[addr]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = 0;
      mem_b[i] = 0;
    end
    rd0a = 0; rd0b = 0; pa_m = 0; pb_m = 0; c_m = 0;
  endtask

  task automatic idle();
    w_en_a = 0; w_en_b = 0; r_en_a = 0; r_en_b = 0; pe_en = 0; pe_clr = 0;
  endtask

  // Evaluate the edge about to happen with the current inputs, queue the expectation, advance.
  task automatic cycle();
    exp_t e;
    logic [15:0] na [4];
    logic [15:0] nb [4];
    for (int p = 0; p < 4; p++) begin
      na[p] = rd_model(r_en_a, ra[p], 1'b1);
      nb[p] = rd_model(r_en_b, rb[p], 1'b0);
    end
    if (pe_clr) begin
      c_m = 0; pa_m = 0; pb_m = 0;
    end else if (pe_en) begin
      c_m  = c_m + 33'(mul(rd0a, rd0b));
      pa_m = rd0a;
      pb_m = rd0b;
    end
    if (w_en_a && w_addr_a != 7'd127) mem_a[w_addr_a] = 32'(w_data_a);
    if (w_en_b && w_addr_b != 7'd127) mem_b[w_addr_b] = 32'(w_data_b);
    rd0a = na[0];
    rd0b = nb[0];
    e.a1 = na[1]; e.a2 = na[2]; e.a3 = na[3];
    e.b1 = nb[1]; e.b2 = nb[2]; e.b3 = nb[3];
    e.pa = pa_m; e.pb = pb_m; e.c = c_m;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("r_data_a1", r_data_a1, mon_e.a1);
      chk("r_data_a2", r_data_a2, mon_e.a2);
      chk("r_data_a3", r_data_a3, mon_e.a3);
      chk("r_data_b1", r_data_b1, mon_e.b1);
      chk("r_data_b2", r_data_b2, mon_e.b2);
      chk("r_data_b3", r_data_b3, mon_e.b3);
      chk("pe_a_out", pe_a_out, mon_e.pa);
      chk("pe_b_out", pe_b_out, mon_e.pb);
      chk("pe_c_out", pe_c_out, mon_e.c);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a1"}, r_data_a1, 0); chk({tag, "_a2"}, r_data_a2, 0); chk({tag, "_a3"}, r_data_a3, 0);
    chk({tag, "_b1"}, r_data_b1, 0); chk({tag, "_b2"}, r_data_b2, 0); chk({tag, "_b3"}, r_data_b3, 0);
    chk({tag, "_pa"}, pe_a_out, 0);  chk({tag, "_pb"}, pe_b_out, 0);  chk({tag, "_c"}, pe_c_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 0;
    idle();
    w_addr_a = 0; w_addr_b = 0; w_data_a = 0; w_data_b = 0;
    for (int p = 0; p < 4; p++) begin
      ra[p] = 0;
      rb[p] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("rst_init");
    rst = 1;

    // Accumulate 0x1234, then reset asynchronously between edges
    w_en_a = 1; w_addr_a = 0; w_data_a = 16'h1234; w_en_b = 1; w_addr_b = 0; w_data_b = 16'h0001; cycle();
    idle(); r_en_a = 1; r_en_b = 1; ra[0] = 0; rb[0] = 0; cycle();
    idle(); pe_en = 1; cycle();
    chk("pre_rst_c", pe_c_out, 33'h1234);
    #3 rst = 0;
    #1 chk_all_zero("async_rst");
    model_reset();
    idle();
    @(negedge clk); @(negedge clk);
    rst = 1;

    // Blank word and post-reset memory contents
    w_en_a = 1; w_addr_a = 7'd127; w_data_a = 16'hBEEF; cycle();
    idle(); r_en_a = 1; ra[1] = 7'd127; ra[3] = 0; cycle();
    chk("blank_a1", r_data_a1, 0);

    // Read latency and read enable gating
    idle(); w_en_a = 1; w_addr_a = 5; w_data_a = 16'h0011; w_en_b = 1; w_addr_b = 9; w_data_b = 16'h0022; cycle();
    idle(); r_en_a = 1; r_en_b = 1; ra[1] = 5; rb[3] = 9; cycle();
    chk("lat_a1", r_data_a1, 16'h0011);
    chk("lat_b3", r_data_b3, 16'h0022);
    idle(); cycle();
    chk("ren0_a1", r_data_a1, 0);

    // Read-first on the same address
    idle(); w_en_a = 1; w_addr_a = 3; w_data_a = 16'h0002; cycle();
    idle(); w_en_a = 1; w_addr_a = 3; w_data_a = 16'h0007; r_en_a = 1; ra[2] = 3; cycle();
    chk("rf_old", r_data_a2, 16'h0002);
    idle(); r_en_a = 1; cycle();
    chk("rf_new", r_data_a2, 16'h0007);

    // MAC stream 1..4 x 5..8
    for (int k = 0; k < 4; k++) begin
      idle(); w_en_a = 1; w_addr_a = 7'(k); w_data_a = 16'(k + 1);
      w_en_b = 1; w_addr_b = 7'(k); w_data_b = 16'(k + 5); cycle();
    end
    idle(); pe_clr = 1; cycle();
    for (int k = 0; k < 5; k++) begin
      idle(); pe_en = (k > 0); r_en_a = (k < 4); r_en_b = (k < 4); ra[0] = 7'(k); rb[0] = 7'(k); cycle();
    end
    chk("mac_c", pe_c_out, 70);
    chk("mac_a", pe_a_out, 4);
    chk("mac_b", pe_b_out, 8);
    idle(); cycle(); cycle();
    chk("hold_c", pe_c_out, 70);
    idle(); pe_clr = 1; pe_en = 1; cycle();
    chk("clr_prio_c", pe_c_out, 0);

    // Wrap: 0xFFFF * 0xFFFF three times
    idle(); w_en_a = 1; w_addr_a = 10; w_data_a = 16'hFFFF; w_en_b = 1; w_addr_b = 10; w_data_b = 16'hFFFF; cycle();
    idle(); r_en_a = 1; r_en_b = 1; ra[0] = 10; rb[0] = 10; cycle();
    repeat (3) begin
      pe_en = 1; cycle();
    end
`ifdef MM_SIGNED_MAC_EN
    chk("wrap_c", pe_c_out, 33'h000000003);
`else
    chk("wrap_c", pe_c_out, 33'h0FFFA0003);
`endif

    // 0xFFFF * 0x0002 from a cleared accumulator
    idle(); w_en_b = 1; w_addr_b = 11; w_data_b = 16'h0002; pe_clr = 1; cycle();
    idle(); r_en_a = 1; r_en_b = 1; ra[0] = 10; rb[0] = 11; cycle();
    idle(); pe_en = 1; cycle();
`ifdef MM_SIGNED_MAC_EN
    chk("neg_c", pe_c_out, 33'h1FFFFFFFE);
`else
    chk("neg_c", pe_c_out, 33'h00001FFFE);
`endif

    // Randomized traffic on a small address window plus the blank word
    for (int n = 0; n < 400; n++) begin
      w_en_a = 1'($urandom_range(0, 1)); w_en_b = 1'($urandom_range(0, 1));
      w_addr_a = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
      w_addr_b = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
      w_data_a = 16'($urandom); w_data_b = 16'($urandom);
      r_en_a = ($urandom_range(0, 4) != 0); r_en_b = ($urandom_range(0, 4) != 0);
      for (int p = 0; p < 4; p++) begin
        ra[p] = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
        rb[p] = ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 15));
      end
      pe_en  = ($urandom_range(0, 3) != 0);
      pe_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();
    chk("sb_drain", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
